// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe move controller: cell codes, FSM states,
// the eight winning lines and a board cell accessor.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;

    typedef enum logic [2:0] {
        P_WAIT,
        P_ISSUE,
        P_CHECK,
        C_WAIT,
        C_ISSUE,
        C_CHECK,
        DONE
    } ttt_state_t;

    localparam int unsigned WIN_LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    // Out-of-range indices read as occupied so they can never be accepted.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] v;
        v = 2'b11;
        for (int unsigned k = 0; k < 9; k++) begin
            if (idx == 4'(k)) v = b[2*k +: 2];
        end
        return v;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line detector: flags when any of the eight lines is fully
// occupied by the given mark.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  mark,
    output logic        line_done
);

    always_comb begin
        line_done = 1'b0;
        for (int unsigned l = 0; l < 8; l++) begin
            if ((cell_at(board, 4'(WIN_LINES[l][0])) == mark) &&
                (cell_at(board, 4'(WIN_LINES[l][1])) == mark) &&
                (cell_at(board, 4'(WIN_LINES[l][2])) == mark))
                line_done = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Turn-sequencing controller: validates player/computer requests against the
// board, issues one-cycle write strobes and detects win/draw after each move.
module ttt_move_ctrl
    import ttt_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        play,
    input  logic [3:0]  player_position,
    input  logic        pc,
    input  logic [3:0]  computer_position,
    input  logic [17:0] board,
    output logic [15:0] p_enable,
    output logic [15:0] c_enable,
    output logic        wrong_move,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        game_over,
    output logic [3:0]  move_count
);

    ttt_state_t  state, next_state;
    logic [15:0] p_enable_d, c_enable_d;
    logic        wrong_move_d, draw_d;
    logic [1:0]  winner_d;
    logic [3:0]  move_count_d;
    logic [1:0]  check_mark;
    logic        line_done;
    logic        p_legal, c_legal;

    assign check_mark = (state == C_CHECK) ? CELL_COMP : CELL_PLAYER;

    ttt_win_detect u_win_detect (
        .board     (board),
        .mark      (check_mark),
        .line_done (line_done)
    );

    assign p_legal = (player_position   <= 4'd8) && (cell_at(board, player_position)   == CELL_EMPTY);
    assign c_legal = (computer_position <= 4'd8) && (cell_at(board, computer_position) == CELL_EMPTY);

    always_comb begin
        next_state   = state;
        p_enable_d   = '0;
        c_enable_d   = '0;
        wrong_move_d = 1'b0;
        winner_d     = winner;
        draw_d       = draw;
        move_count_d = move_count;
        case (state)
            P_WAIT: begin
                if (play) begin
                    if (p_legal) begin
                        p_enable_d = 16'd1 << player_position;
                        next_state = P_ISSUE;
                    end else begin
                        wrong_move_d = 1'b1;
                    end
                end
            end
            P_ISSUE: next_state = P_CHECK;
            P_CHECK: begin
                if (line_done) begin
                    winner_d   = CELL_PLAYER;
                    next_state = DONE;
                end else begin
                    move_count_d = move_count + 4'd1;
                    if (move_count_d == 4'd9) begin
                        draw_d     = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = C_WAIT;
                    end
                end
            end
            C_WAIT: begin
                if (pc) begin
                    if (c_legal) begin
                        c_enable_d = 16'd1 << computer_position;
                        next_state = C_ISSUE;
                    end else begin
                        wrong_move_d = 1'b1;
                    end
                end
            end
            C_ISSUE: next_state = C_CHECK;
            C_CHECK: begin
                if (line_done) begin
                    winner_d   = CELL_COMP;
                    next_state = DONE;
                end else begin
                    move_count_d = move_count + 4'd1;
                    if (move_count_d == 4'd9) begin
                        draw_d     = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = P_WAIT;
                    end
                end
            end
            default: next_state = DONE;
        endcase
    end

    // turn and game_over are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= P_WAIT;
            p_enable   <= '0;
            c_enable   <= '0;
            wrong_move <= 1'b0;
            turn       <= 1'b0;
            winner     <= '0;
            draw       <= 1'b0;
            game_over  <= 1'b0;
            move_count <= '0;
        end else begin
            state      <= next_state;
            p_enable   <= p_enable_d;
            c_enable   <= c_enable_d;
            wrong_move <= wrong_move_d;
            turn       <= (next_state == C_WAIT) || (next_state == C_ISSUE) || (next_state == C_CHECK);
            winner     <= winner_d;
            draw       <= draw_d;
            game_over  <= (next_state == DONE);
            move_count <= move_count_d;
        end
    end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: board register bank model plus a game-level
// reference model driven by directed games and random requests.
module tb_ttt_move_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [3:0]  player_position = '0;
    logic        pc = 1'b0;
    logic [3:0]  computer_position = '0;
    logic [17:0] board;
    logic [15:0] p_enable, c_enable;
    logic        wrong_move, turn, draw, game_over;
    logic [1:0]  winner;
    logic [3:0]  move_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference game state
    int  cells [9];
    int  m_turn, m_winner, m_count;
    bit  m_draw, m_over;

    ttt_move_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .play              (play),
        .player_position   (player_position),
        .pc                (pc),
        .computer_position (computer_position),
        .board             (board),
        .p_enable          (p_enable),
        .c_enable          (c_enable),
        .wrong_move        (wrong_move),
        .turn              (turn),
        .winner            (winner),
        .draw              (draw),
        .game_over         (game_over),
        .move_count        (move_count)
    );

    always #5 clock = ~clock;

    // Board register bank
    always @(posedge clock or posedge reset) begin
        if (reset) board <= '0;
        else begin
            for (int k = 0; k < 9; k++) begin
                if (p_enable[k]) board[2*k +: 2] <= 2'b01;
                if (c_enable[k]) board[2*k +: 2] <= 2'b10;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit owns_line(input int mark);
        int lines [8][3] = '{'{0,1,2},'{3,4,5},'{6,7,8},'{0,3,6},'{1,4,7},'{2,5,8},'{0,4,8},'{2,4,6}};
        for (int l = 0; l < 8; l++)
            if (cells[lines[l][0]] == mark && cells[lines[l][1]] == mark && cells[lines[l][2]] == mark)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".turn"},  32'(turn),       32'(m_turn));
        check({tag, ".win"},   32'(winner),     32'(m_winner));
        check({tag, ".draw"},  32'(draw),       32'(m_draw));
        check({tag, ".over"},  32'(game_over),  32'(m_over));
        check({tag, ".count"}, 32'(move_count), 32'(m_count));
    endtask

    task automatic model_reset();
        foreach (cells[k]) cells[k] = 0;
        m_turn = 0; m_winner = 0; m_count = 0; m_draw = 0; m_over = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; play = 1'b0; pc = 1'b0;
        model_reset();
        #2;
        check("rst.p_en", 32'(p_enable), 0);
        check("rst.c_en", 32'(c_enable), 0);
        check("rst.wrong", 32'(wrong_move), 0);
        check_status("rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    // Present one request for one cycle; for an accepted move also walk through
    // the strobe and line-check cycles. Called #1 after a rising edge.
    task automatic request(input bit rp, input bit rc, input int ppos, input int cpos);
        int  pos, side;
        bit  asked, legal;
        play = rp; pc = rc;
        player_position = 4'(ppos); computer_position = 4'(cpos);
        @(posedge clock); #1;
        play = 1'b0; pc = 1'b0;
        side  = m_turn;
        pos   = (side == 0) ? ppos : cpos;
        asked = !m_over && ((side == 0) ? rp : rc);
        legal = asked && pos <= 8 && cells[pos] == 0;
        if (!legal) begin
            check("req.p_en", 32'(p_enable), 0);
            check("req.c_en", 32'(c_enable), 0);
            check("req.wrong", 32'(wrong_move), 32'(asked));
            check_status("req");
            return;
        end
        check("mv.p_en", 32'(p_enable), (side == 0) ? (32'd1 << pos) : 0);
        check("mv.c_en", 32'(c_enable), (side == 1) ? (32'd1 << pos) : 0);
        check("mv.wrong", 32'(wrong_move), 0);
        cells[pos] = side + 1;
        @(posedge clock); #1;
        check("iss.p_en", 32'(p_enable), 0);
        check("iss.c_en", 32'(c_enable), 0);
        @(posedge clock); #1;
        if (owns_line(side + 1)) begin
            m_winner = side + 1; m_over = 1;
        end else begin
            m_count++;
            if (m_count == 9) begin m_draw = 1; m_over = 1; end
            else m_turn = 1 - side;
        end
        if (m_over) m_turn = 0;
        check_status("chk");
    endtask

    task automatic p_move(input int pos); request(1, 0, pos, 0); endtask
    task automatic c_move(input int pos); request(0, 1, 0, pos); endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // First move, then illegal computer move onto occupied cell
        p_move(4);
        c_move(4);
        c_move(0);

        // Player wins on the top row
        do_reset();
        p_move(0); c_move(3); p_move(1); c_move(4); p_move(2);
        p_move(5); c_move(6); request(1, 1, 7, 8);

        // Out-of-range indices and simultaneous requests
        do_reset();
        p_move(9); p_move(15);
        request(1, 1, 2, 3);
        c_move(15); c_move(9);
        request(1, 0, 5, 6);
        c_move(6);

        // Full board without a line
        do_reset();
        p_move(0); c_move(1); p_move(2); c_move(4); p_move(3);
        c_move(5); p_move(7); c_move(6); p_move(8);
        p_move(4);

        // Reset asserted while the write strobe is high
        do_reset();
        play = 1'b1; player_position = 4'd6;
        @(posedge clock); #1;
        play = 1'b0;
        check("issrst.p_en_pre", 32'(p_enable), 32'h40);
        reset = 1'b1;
        model_reset();
        #1;
        check("issrst.p_en", 32'(p_enable), 0);
        check("issrst.c_en", 32'(c_enable), 0);
        check("issrst.wrong", 32'(wrong_move), 0);
        check_status("issrst");
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        p_move(6);

        // Random games
        for (int g = 0; g < 30; g++) begin
            do_reset();
            for (int r = 0; r < 40; r++) begin
                int pp, cp;
                pp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
                cp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
                request(1'($urandom), 1'($urandom), pp, cp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

endmodule
